// File: rtl/cla_pkg.sv
// Shared definitions for the registered carry-lookahead adder.
//   CLA_GROUP_W : width of one lookahead cell
//   CLA_MAX_N   : widest p/g vector the lookahead function accepts
//   la_carry    : flat (fully expanded) lookahead carry into position k,
//                 used for both the bit level inside a group and the
//                 group level across groups.
package cla_pkg;

    localparam int CLA_GROUP_W = 4;
    localparam int CLA_MAX_N   = 16;

    // Carry into position k as a flat sum of products:
    //   c[k] = OR_j<k ( g[j] & p[j+1] & ... & p[k-1] ) | ( p[0] & ... & p[k-1] & cin )
    // Every term is built independently, so no ripple chain is formed.
    // Loop bounds are fixed; k only gates terms, so this unrolls statically.
    function automatic logic la_carry(
        input logic [CLA_MAX_N-1:0] p,
        input logic [CLA_MAX_N-1:0] g,
        input logic                 cin,
        input int                   k
    );
        logic c;
        logic term;
        c = 1'b0;
        for (int j = 0; j < CLA_MAX_N; j++) begin
            if (j < k) begin
                term = g[j];
                for (int m = 0; m < CLA_MAX_N; m++) begin
                    if (m > j && m < k) term = term & p[m];
                end
                c = c | term;
            end
        end
        term = cin;
        for (int m = 0; m < CLA_MAX_N; m++) begin
            if (m < k) term = term & p[m];
        end
        return c | term;
    endfunction

endpackage

// File: rtl/cla4_block.sv
// 4-bit carry-lookahead cell.
//   a, b : 4-bit operands
//   cin  : carry into bit 0
//   s    : 4-bit sum
//   gp   : group propagate (all four bits propagate)
//   gg   : group generate (carry out of the group independent of cin)
module cla4_block
    import cla_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       gp,
    output logic       gg
);

    logic [3:0]           p, g;
    logic [CLA_MAX_N-1:0] p_ext, g_ext;
    logic [3:0]           c;

    assign p = a ^ b;
    assign g = a & b;

    always_comb begin
        p_ext      = '0;
        g_ext      = '0;
        p_ext[3:0] = p;
        g_ext[3:0] = g;
    end

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign c[i] = la_carry(p_ext, g_ext, cin, i);
        assign s[i] = p[i] ^ c[i];
    end

    assign gp = &p;
    // Carry out of bit 3 with cin forced low is exactly g3|p3g2|p3p2g1|p3p2p1g0.
    assign gg = la_carry(p_ext, g_ext, 1'b0, 4);

endmodule

// File: rtl/cla_adder.sv
// Registered carry-lookahead adder: {c_out, sum} = a + b + c_in, one cycle
// latency, a new operand pair every cycle.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears all outputs
//   a, b  : WIDTH-bit unsigned operands
//   c_in  : carry-in
//   sum   : registered (a + b + c_in) mod 2^WIDTH
//   c_out : registered carry out of bit WIDTH-1
//   grp_p : registered word propagate, for cascading
//   grp_g : registered word generate (independent of c_in), for cascading
module cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             grp_p,
    output logic             grp_g
);

    localparam int NG = WIDTH / CLA_GROUP_W;

    if (WIDTH <= 0 || (WIDTH % CLA_GROUP_W) != 0) begin : g_bad_width
        $error("cla_adder: WIDTH must be a positive multiple of 4");
    end
    if (NG > CLA_MAX_N) begin : g_too_wide
        $error("cla_adder: WIDTH exceeds the lookahead function capacity");
    end

    logic [NG-1:0]        gp, gg;
    logic [CLA_MAX_N-1:0] gp_ext, gg_ext;
    logic [NG:0]          gc;          // carry into each group; gc[NG] is c_out
    logic [WIDTH-1:0]     sum_d, sum_q;
    logic                 c_out_d, c_out_q;
    logic                 grp_p_d, grp_p_q;
    logic                 grp_g_d, grp_g_q;

    always_comb begin
        gp_ext       = '0;
        gg_ext       = '0;
        gp_ext[NG-1:0] = gp;
        gg_ext[NG-1:0] = gg;
    end

    // Second-level lookahead: each group's carry-in comes straight from
    // lower-group GP/GG and c_in, never from the neighbouring group's sum path.
    for (genvar k = 0; k <= NG; k++) begin : g_gcarry
        assign gc[k] = la_carry(gp_ext, gg_ext, c_in, k);
    end

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla4_block u_cla4 (
            .a   (a[k*CLA_GROUP_W +: CLA_GROUP_W]),
            .b   (b[k*CLA_GROUP_W +: CLA_GROUP_W]),
            .cin (gc[k]),
            .s   (sum_d[k*CLA_GROUP_W +: CLA_GROUP_W]),
            .gp  (gp[k]),
            .gg  (gg[k])
        );
    end

    assign c_out_d = gc[NG];
    assign grp_p_d = &gp;
    assign grp_g_d = la_carry(gp_ext, gg_ext, 1'b0, NG);

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
            grp_p_q <= 1'b0;
            grp_g_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            grp_p_q <= grp_p_d;
            grp_g_q <= grp_g_d;
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign grp_p = grp_p_q;
    assign grp_g = grp_g_q;

endmodule

// File: tb/tb_cla_adder.sv
// Self-checking bench for cla_adder: directed WIDTH=4 vectors, reset and
// back-to-back streaming, exhaustive WIDTH=4 and random WIDTH=8/16 sweeps.
module tb_cla_adder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // WIDTH=4 instance
    logic [3:0] a4 = '0, b4 = '0, s4;
    logic       ci4 = 1'b0, co4, gp4, gg4;
    cla_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .c_in(ci4),
        .sum(s4), .c_out(co4), .grp_p(gp4), .grp_g(gg4)
    );

    // WIDTH=8 instance
    logic [7:0] a8 = '0, b8 = '0, s8;
    logic       ci8 = 1'b0, co8, gp8, gg8;
    cla_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c_in(ci8),
        .sum(s8), .c_out(co8), .grp_p(gp8), .grp_g(gg8)
    );

    // WIDTH=16 instance
    logic [15:0] a16 = '0, b16 = '0, s16;
    logic        ci16 = 1'b0, co16, gp16, gg16;
    cla_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .c_in(ci16),
        .sum(s16), .c_out(co16), .grp_p(gp16), .grp_g(gg16)
    );

    // Directed vectors 2,3,4: {a, b, c_in} and hand-computed {sum, c_out, grp_p, grp_g}
    logic [3:0] va [3] = '{4'hF, 4'hA, 4'hF};
    logic [3:0] vb [3] = '{4'h0, 4'h5, 4'hF};
    logic       vc [3] = '{1'b1, 1'b0, 1'b1};
    logic [3:0] es [3] = '{4'h0, 4'hF, 4'hF};
    logic       eco[3] = '{1'b1, 1'b0, 1'b1};
    logic       egp[3] = '{1'b1, 1'b1, 1'b0};
    logic       egg[3] = '{1'b0, 1'b0, 1'b1};

    // Drive at the falling edge, sample 1 time unit after the next rising edge.
    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic c);
        @(negedge clk);
        a4 = a; b4 = b; ci4 = c;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Load a nonzero result first so the clear is observable.
        drive4(4'hF, 4'hF, 1'b1);
        settle();
        @(negedge clk);
        rst = 1'b1;
        settle();
        checks++;
        if ({s4, co4, gp4, gg4} !== 7'b0) begin
            errors++;
            $display("FAIL reset_clear: got sum=%h c_out=%b grp_p=%b grp_g=%b want all 0",
                     s4, co4, gp4, gg4);
        end
        @(negedge clk);
        rst = 1'b0;
        a4 = 4'h0; b4 = 4'h0; ci4 = 1'b0;
        settle();
        checks++;
        if ({s4, co4, gp4, gg4} !== 7'b0) begin
            errors++;
            $display("FAIL reset_zero_add: got sum=%h c_out=%b grp_p=%b grp_g=%b want 0/0/0/0",
                     s4, co4, gp4, gg4);
        end
    endtask

    task automatic test_vectors();
        for (int i = 0; i < 3; i++) begin
            drive4(va[i], vb[i], vc[i]);
            settle();
            checks++;
            if ({s4, co4, gp4, gg4} !== {es[i], eco[i], egp[i], egg[i]}) begin
                errors++;
                $display("FAIL vector_%0d: got sum=%h c_out=%b grp_p=%b grp_g=%b want sum=%h c_out=%b grp_p=%b grp_g=%b",
                         i + 2, s4, co4, gp4, gg4, es[i], eco[i], egp[i], egg[i]);
            end
        end
    endtask

    // Vectors 2,3,4 on consecutive cycles; with_rst asserts rst alongside vector 3.
    // Each falling edge checks the result of the previous cycle and drives the next.
    task automatic test_back_to_back(input bit with_rst);
        logic [6:0] exp;
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (with_rst && i == 2) exp = 7'b0;
                else exp = {es[i-1], eco[i-1], egp[i-1], egg[i-1]};
                checks++;
                if ({s4, co4, gp4, gg4} !== exp) begin
                    errors++;
                    $display("FAIL b2b%s_cycle_%0d: got %b want %b",
                             with_rst ? "_rst" : "", i, {s4, co4, gp4, gg4}, exp);
                end
            end
            if (i < 3) begin
                a4 = va[i]; b4 = vb[i]; ci4 = vc[i];
                rst = with_rst && (i == 1);
            end else begin
                rst = 1'b0;
            end
        end
    endtask

    task automatic test_exhaustive4();
        logic [4:0] exp;
        int bad = 0;
        for (int c = 0; c < 2; c++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++) begin
                    drive4(x[3:0], y[3:0], c[0]);
                    settle();
                    exp = x[4:0] + y[4:0] + {4'b0, c[0]};
                    checks++;
                    if ({co4, s4} !== exp ||
                        gp4 !== ((x[3:0] ^ y[3:0]) == 4'hF) ||
                        gg4 !== ((x + y) > 15)) begin
                        errors++;
                        if (bad < 10)
                            $display("FAIL exh4 a=%h b=%h cin=%0d: got %b_%b%b want %b_%b%b",
                                     x[3:0], y[3:0], c, {co4, s4}, gp4, gg4,
                                     exp, ((x[3:0] ^ y[3:0]) == 4'hF), ((x + y) > 15));
                        bad++;
                    end
                end
    endtask

    task automatic test_random_wide();
        logic [8:0]  e8;
        logic [16:0] e16;
        logic [7:0]  ra8, rb8;
        logic [15:0] ra16, rb16;
        logic        rc;
        int bad = 0;
        for (int i = 0; i < 300; i++) begin
            ra8  = 8'($urandom);  rb8  = 8'($urandom);
            ra16 = 16'($urandom); rb16 = 16'($urandom);
            rc   = 1'($urandom);
            // Force the all-ones wrap and full-propagate corners early on.
            if (i == 0) begin ra8 = 8'hFF; rb8 = 8'hFF; ra16 = 16'hFFFF; rb16 = 16'hFFFF; rc = 1'b1; end
            if (i == 1) begin ra8 = 8'hF0; rb8 = 8'h0F; ra16 = 16'h1234; rb16 = 16'hEDCB; rc = 1'b1; end
            @(negedge clk);
            a8 = ra8; b8 = rb8; ci8 = rc;
            a16 = ra16; b16 = rb16; ci16 = rc;
            settle();
            e8  = {1'b0, ra8} + {1'b0, rb8} + {8'b0, rc};
            e16 = {1'b0, ra16} + {1'b0, rb16} + {16'b0, rc};
            checks++;
            if ({co8, s8} !== e8 || gp8 !== ((ra8 ^ rb8) == 8'hFF) ||
                gg8 !== (({1'b0, ra8} + {1'b0, rb8}) > 9'd255)) begin
                errors++;
                if (bad < 10)
                    $display("FAIL rand8 a=%h b=%h cin=%b: got %h p%b g%b want %h", ra8, rb8, rc,
                             {co8, s8}, gp8, gg8, e8);
                bad++;
            end
            checks++;
            if ({co16, s16} !== e16 || gp16 !== ((ra16 ^ rb16) == 16'hFFFF) ||
                gg16 !== (({1'b0, ra16} + {1'b0, rb16}) > 17'd65535)) begin
                errors++;
                if (bad < 10)
                    $display("FAIL rand16 a=%h b=%h cin=%b: got %h p%b g%b want %h", ra16, rb16, rc,
                             {co16, s16}, gp16, gg16, e16);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_exhaustive4();
        test_random_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
